// File: rtl/dl_port_responder_pkg.sv
// Shared types and helpers for the toggle req/ack port responder.
package dl_port_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  localparam int DEF_AW = 23;
  localparam int DEF_DW = 16;

  // Width of the WAIT-state cycle counter; never narrower than one bit.
  function automatic int tmo_cnt_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/dl_port_responder_if.sv
// Port-side (toggle req/ack) and backend-side (level req / ready strobe) signal bundle.
interface dl_port_responder_if #(
  parameter int AW = 23,
  parameter int DW = 16
);
  localparam int BW = DW / 8;

  logic          port_req;
  logic          port_ack;
  logic [AW-1:0] port_a;
  logic [BW-1:0] port_ds;
  logic          port_we;
  logic [DW-1:0] port_d;
  logic [DW-1:0] port_q;
  logic          port_err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_d;
  logic [DW-1:0] mem_q;
  logic          mem_ready;
  logic          busy;

  // Master is the initiator plus memory backend; slave is the responder.
  modport master (
    output port_req, port_a, port_ds, port_we, port_d, mem_q, mem_ready,
    input  port_ack, port_q, port_err, mem_req, mem_we, mem_addr, mem_be, mem_d, busy
  );

  modport slave (
    input  port_req, port_a, port_ds, port_we, port_d, mem_q, mem_ready,
    output port_ack, port_q, port_err, mem_req, mem_we, mem_addr, mem_be, mem_d, busy
  );

endinterface

// File: rtl/dl_port_responder_sync.sv
// Registers the toggle request once and flags a pending access when it differs from ack.
module dl_port_cdc_free_toggle_sync (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic req_i,
  input  logic ack_i,
  output logic req_r_o,
  output logic pending_o
);

  logic req_q;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) req_q <= 1'b0;
    else          req_q <= req_i;
  end

  assign req_r_o   = req_q;
  assign pending_o = req_q ^ ack_i;

endmodule

// File: rtl/dl_port_responder.sv
// Responder for the toggle req/ack port: one latched access per toggle on a ready-handshaked backend.
// Optional DL_PORT_CHECKSUM_EN adds a running 16-bit byte checksum of completed writes.
module dl_port_responder
  import dl_port_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = 255
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  dl_port_responder_if.slave bus
`ifdef DL_PORT_CHECKSUM_EN
  ,
  output logic [15:0]   csum,
  input  logic          csum_clr
`endif
);

  localparam int BW = DW / 8;
  localparam int CW = tmo_cnt_w(TIMEOUT);

  state_e        state_q;
  logic          ack_q;
  logic [DW-1:0] rdata_q;
  logic          err_q;
  logic          mreq_q;
  logic          mwe_q;
  logic [AW-1:0] maddr_q;
  logic [BW-1:0] mbe_q;
  logic [DW-1:0] mdata_q;
  logic [CW-1:0] cnt_q;
  logic          req_r;
  logic          pending;

  dl_port_cdc_free_toggle_sync u_sync (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .req_i     (bus.port_req),
    .ack_i     (ack_q),
    .req_r_o   (req_r),
    .pending_o (pending)
  );

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      mreq_q  <= 1'b0;
      mwe_q   <= 1'b0;
      maddr_q <= '0;
      mbe_q   <= '0;
      mdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pending) begin
            maddr_q <= bus.port_a;
            mbe_q   <= bus.port_ds;
            mwe_q   <= bus.port_we;
            mdata_q <= bus.port_d;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          mreq_q  <= 1'b1;
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // A ready strobe in the final counted cycle still completes cleanly.
          if (bus.mem_ready) begin
            mreq_q <= 1'b0;
            if (!mwe_q) rdata_q <= bus.mem_q;
            state_q <= DONE;
          end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT))) begin
            mreq_q  <= 1'b0;
            err_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          ack_q   <= req_r;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.port_ack = ack_q;
  assign bus.port_q   = rdata_q;
  assign bus.port_err = err_q;
  assign bus.mem_req  = mreq_q;
  assign bus.mem_we   = mwe_q;
  assign bus.mem_addr = maddr_q;
  assign bus.mem_be   = mbe_q;
  assign bus.mem_d    = mdata_q;
  assign bus.busy     = (state_q != IDLE);

`ifdef DL_PORT_CHECKSUM_EN
  function automatic logic [15:0] be_sum(input logic [BW-1:0] be, input logic [DW-1:0] d);
    logic [15:0] s;
    s = '0;
    for (int i = 0; i < BW; i++) begin
      if (be[i]) s = s + {8'h00, d[i*8 +: 8]};
    end
    return s;
  endfunction

  logic [15:0] csum_q;
  logic [15:0] csum_d;

  always_comb begin
    csum_d = csum_q;
    if (csum_clr)
      csum_d = '0;
    else if ((state_q == WAIT) && bus.mem_ready && mwe_q)
      csum_d = csum_q + be_sum(mbe_q, mdata_q);
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) csum_q <= '0;
    else          csum_q <= csum_d;
  end

  assign csum = csum_q;
`endif

endmodule

// File: tb/tb_dl_port_responder.sv
// Directed bench for dl_port_responder: vector table plus reset, stream and checksum sequences.
module tb_dl_port_responder;

  localparam int AW  = 23;
  localparam int DW  = 16;
  localparam int TMO = 8;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  dl_port_responder_if #(.AW(AW), .DW(DW)) ifc ();

`ifdef DL_PORT_CHECKSUM_EN
  logic [15:0] csum;
  logic        csum_clr = 1'b0;
`endif

  dl_port_responder #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (ifc.slave)
`ifdef DL_PORT_CHECKSUM_EN
    ,
    .csum     (csum),
    .csum_clr (csum_clr)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Results of the most recent access, captured from the backend side.
  int          lat, reqc;
  logic [AW-1:0] cap_addr;
  logic [1:0]  cap_be;
  logic [DW-1:0] cap_d;
  logic        cap_we;

  // rdy = index of the WAIT cycle carrying mem_ready (1 = first), 0 = never ready.
  task automatic do_access(input logic we, input logic [AW-1:0] a, input logic [1:0] ds,
                           input logic [DW-1:0] d, input int rdy, input logic [DW-1:0] q);
    logic ack0;
    int   widx;
    @(negedge clk_sys);
    ack0         = ifc.port_ack;
    ifc.port_a   = a;
    ifc.port_ds  = ds;
    ifc.port_we  = we;
    ifc.port_d   = d;
    ifc.mem_q    = q;
    ifc.port_req = ~ifc.port_req;
    @(posedge clk_sys);
    lat = 0; reqc = 0; widx = 0;
    while ((ifc.port_ack == ack0) && (lat < 300)) begin
      @(negedge clk_sys);
      ifc.mem_ready = 1'b0;
      if (lat == 1) begin
        ifc.port_a  = ~a;
        ifc.port_d  = ~d;
        ifc.port_ds = ~ds;
        ifc.port_we = ~we;
      end
      if (ifc.mem_req) begin
        widx++;
        reqc++;
        cap_addr = ifc.mem_addr;
        cap_be   = ifc.mem_be;
        cap_d    = ifc.mem_d;
        cap_we   = ifc.mem_we;
        if (widx == rdy) ifc.mem_ready = 1'b1;
      end
      @(posedge clk_sys);
      lat++;
      #1;
    end
    if (lat >= 300) chk("ack_wait_bound", 64'(lat), 64'd0);
    @(negedge clk_sys);
    ifc.mem_ready = 1'b0;
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] a;
    logic [1:0]    ds;
    logic [DW-1:0] d;
    int            rdy;
    logic [DW-1:0] q;
    int            lat;
    int            reqc;
    logic [DW-1:0] pq;
    logic          err;
  } vec_t;

  vec_t tbl[8];
  logic stay_ok;

  initial begin
    ifc.port_req  = 1'b0;
    ifc.port_a    = '0;
    ifc.port_ds   = '0;
    ifc.port_we   = 1'b0;
    ifc.port_d    = '0;
    ifc.mem_q     = '0;
    ifc.mem_ready = 1'b0;

    //           we    addr         ds     d         rdy q         lat reqc pq        err
    tbl[0] = '{1'b1, 23'h000123, 2'b01, 16'hABCD, 2, 16'h0000, 5,  2, 16'h0000, 1'b0};
    tbl[1] = '{1'b0, 23'h000010, 2'b11, 16'h0000, 1, 16'h5A3C, 4,  1, 16'h5A3C, 1'b0};
    tbl[2] = '{1'b1, 23'h7FFFFF, 2'b10, 16'h1234, 3, 16'hFFFF, 6,  3, 16'h5A3C, 1'b0};
    tbl[3] = '{1'b1, 23'h000055, 2'b00, 16'h5555, 1, 16'h0000, 4,  1, 16'h5A3C, 1'b0};
    tbl[4] = '{1'b0, 23'h00002A, 2'b11, 16'h0000, 4, 16'h8001, 7,  4, 16'h8001, 1'b0};
    tbl[5] = '{1'b0, 23'h0003FF, 2'b11, 16'h0000, 9, 16'h0F0F, 12, 9, 16'h0F0F, 1'b0};
    tbl[6] = '{1'b0, 23'h000400, 2'b11, 16'h0000, 0, 16'hDEAD, 12, 9, 16'h0F0F, 1'b1};
    tbl[7] = '{1'b1, 23'h000401, 2'b11, 16'hBEEF, 1, 16'h0000, 4,  1, 16'h0F0F, 1'b1};

    // Reset state
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_ack",   64'(ifc.port_ack), 64'd0);
    chk("rst_q",     64'(ifc.port_q),   64'd0);
    chk("rst_err",   64'(ifc.port_err), 64'd0);
    chk("rst_mreq",  64'(ifc.mem_req),  64'd0);
    chk("rst_mwe",   64'(ifc.mem_we),   64'd0);
    chk("rst_maddr", 64'(ifc.mem_addr), 64'd0);
    chk("rst_mbe",   64'(ifc.mem_be),   64'd0);
    chk("rst_md",    64'(ifc.mem_d),    64'd0);
    chk("rst_busy",  64'(ifc.busy),     64'd0);
    @(negedge clk_sys);
    reset_n = 1'b1;

`ifdef DL_PORT_CHECKSUM_EN
    chk("csum_rst", 64'(csum), 64'd0);
    for (int i = 1; i <= 16; i++) begin
      if (i % 2 == 1) do_access(1'b1, 23'(i), 2'b01, {8'hEE, 8'(i)}, 1, 16'h0000);
      else            do_access(1'b1, 23'(i), 2'b10, {8'(i), 8'hEE}, 1, 16'h0000);
    end
    chk("csum_sum", 64'(csum), 64'h0088);
    @(negedge clk_sys);
    csum_clr = 1'b1;
    @(negedge clk_sys);
    csum_clr = 1'b0;
    chk("csum_clr", 64'(csum), 64'd0);
`endif

    for (int i = 0; i < 8; i++) begin
      do_access(tbl[i].we, tbl[i].a, tbl[i].ds, tbl[i].d, tbl[i].rdy, tbl[i].q);
      chk($sformatf("v%0d_lat", i),   64'(lat),          64'(tbl[i].lat));
      chk($sformatf("v%0d_reqc", i),  64'(reqc),         64'(tbl[i].reqc));
      chk($sformatf("v%0d_addr", i),  64'(cap_addr),     64'(tbl[i].a));
      chk($sformatf("v%0d_be", i),    64'(cap_be),       64'(tbl[i].ds));
      chk($sformatf("v%0d_d", i),     64'(cap_d),        64'(tbl[i].d));
      chk($sformatf("v%0d_we", i),    64'(cap_we),       64'(tbl[i].we));
      chk($sformatf("v%0d_q", i),     64'(ifc.port_q),   64'(tbl[i].pq));
      chk($sformatf("v%0d_err", i),   64'(ifc.port_err), 64'(tbl[i].err));
      chk($sformatf("v%0d_busy", i),  64'(ifc.busy),     64'd0);
      chk($sformatf("v%0d_mreq", i),  64'(ifc.mem_req),  64'd0);
    end

    // mem_ready while idle must not disturb anything
    @(negedge clk_sys);
    ifc.mem_q     = 16'h1111;
    ifc.mem_ready = 1'b1;
    @(negedge clk_sys);
    ifc.mem_ready = 1'b0;
    @(negedge clk_sys);
    chk("idle_rdy_q",    64'(ifc.port_q),   64'h0F0F);
    chk("idle_rdy_busy", 64'(ifc.busy),     64'd0);
    chk("idle_rdy_ack",  64'(ifc.port_ack), 64'(ifc.port_req));

    // Download stream of back-to-back writes
    for (int i = 0; i < 256; i++) begin
      do_access(1'b1, 23'(24'h1000 + i), 2'b11, 16'(i * 7 + 3), (i % 3) + 1, 16'h0000);
      chk($sformatf("dl%0d", i), {24'(cap_we), 23'(cap_addr), 16'(cap_d)},
          {24'd1, 23'(24'h1000 + i), 16'(i * 7 + 3)});
    end
    chk("dl_parity", 64'(ifc.port_ack), 64'(ifc.port_req));

    // Reset in the middle of WAIT on a 1->0 request toggle
    if (ifc.port_ack == 1'b0) do_access(1'b0, 23'h77, 2'b11, 16'h0, 1, 16'h4242);
    chk("pre_rst_ack", 64'(ifc.port_ack), 64'd1);
    @(negedge clk_sys);
    ifc.port_req = 1'b0;
    for (int k = 0; k < 20 && !ifc.mem_req; k++) @(negedge clk_sys);
    chk("mid_wait_mreq", 64'(ifc.mem_req), 64'd1);
    reset_n = 1'b0;
    @(posedge clk_sys);
    #1;
    chk("mid_rst_mreq", 64'(ifc.mem_req),  64'd0);
    chk("mid_rst_ack",  64'(ifc.port_ack), 64'd0);
    chk("mid_rst_busy", 64'(ifc.busy),     64'd0);
    chk("mid_rst_err",  64'(ifc.port_err), 64'd0);
    chk("mid_rst_q",    64'(ifc.port_q),   64'd0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    stay_ok = 1'b1;
    repeat (10) begin
      @(posedge clk_sys);
      #1;
      if (ifc.port_ack !== 1'b0 || ifc.busy !== 1'b0 || ifc.mem_req !== 1'b0) stay_ok = 1'b0;
    end
    chk("post_rst_quiet", 64'(stay_ok), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
